jedro_1_alu_arb: RTL and testbench
==================================

# jedro_1_alu_arb

Two-requester arbiter and sequencer in front of `jedro_1_alu`. It shares the single registered ALU between the core pipeline (requester 0) and an auxiliary unit (requester 1), such as address generation or CSR update. It issues at most one operation per cycle and tracks the ALU's fixed one-cycle latency. Results return in order through a 2-entry response FIFO, tagged with the owning requester.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `OP_WIDTH`, 4, ALU op-select width
- `ADDR_WIDTH`, 5, destination register address width
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `rN_valid_i` in 1 (N=0,1): request valid
- `rN_ready_o` out 1: request accepted this cycle
- `rN_op_i` in OP_WIDTH; `rN_opa_i`, `rN_opb_i` in DATA_WIDTH; `rN_addr_i` in ADDR_WIDTH; `rN_wb_i` in 1: request payload
- `alu_op_sel_o` out OP_WIDTH; `alu_opa_o`, `alu_opb_o` out DATA_WIDTH; `alu_dest_addr_o` out ADDR_WIDTH; `alu_wb_o` out 1: drive ALU inputs
- `alu_res_i` in DATA_WIDTH; `alu_overflow_i` in 1; `alu_dest_addr_i` in ADDR_WIDTH; `alu_wb_i` in 1: registered ALU outputs
- `rsp_valid_o` out 1; `rsp_ready_i` in 1: response handshake
- `rsp_id_o` out 1: owning requester (0/1)
- `rsp_res_o` out DATA_WIDTH; `rsp_overflow_o` out 1; `rsp_addr_o` out ADDR_WIDTH; `rsp_wb_o` out 1: response payload

## Operation
- Issue occurs when `rN_valid_i && rN_ready_o` is high at a rising edge. At most one requester is ready in any cycle.
- Occupancy = `inflight` (0/1) + FIFO count (0..2). `can_issue` = occupancy < 2, or occupancy == 2 with a response pop this cycle.
- Grant goes to the winning valid requester per arbitration (see Configuration). `rN_ready_o` = grant_N && `can_issue`.
- `rN_ready_o` may depend on both valids. Requesters must not gate valid on ready, and must hold payload stable until accepted.
- ALU drive is combinational from the granted payload while issuing. When idle: `alu_wb_o`=0, operands 0, op 0, addr 0.
- Register `inflight` <= issue; `inflight_id` <= granted id.
- When `inflight`=1, the cycle after issue pushes {alu_res_i, alu_overflow_i, alu_dest_addr_i, alu_wb_i, inflight_id} into the FIFO. The push is unconditional; the credit rule guarantees space.
- FIFO head drives the `rsp_*` outputs. Pop occurs on `rsp_valid_o && rsp_ready_i`. Push and pop in the same cycle are legal at any count.
- Responses come out strictly in issue order.

## Timing
- Issue handshake at edge E0, ALU captures at E0, FIFO push at E1. `rsp_valid_o` is high in the cycle after E1: 2-cycle latency with the FIFO empty.
- Throughput: 1 issue/cycle sustained while `rsp_ready_i`=1.
- With `rsp_ready_i`=0: at most 2 issues are accepted, then both `rN_ready_o`=0 until a pop.
- Reset values: `rsp_valid_o`=0, all `rsp_*`=0, `alu_wb_o`=0, ALU drive 0, `inflight`=0, FIFO empty, RR pointer = "last granted 1".
- Reset mid-operation: in-flight and buffered results are discarded. An ALU output arriving in the cycle after reset deasserts is ignored, because `inflight`=0.
- The ALU must be reset together with this block (its `rstn_i` = ~`rst_i`).

## Configuration
- `JEDRO_1_ALU_ARB_RR_EN`:
  - Defined: round-robin. With both valid, grant the requester not last granted. The pointer updates only on an actual issue.
  - Undefined: fixed priority; requester 0 always wins when valid. The pointer logic is not compiled.

## Test plan
- Single request: r0 ADD 5+7, addr 3, wb 1 -> `rsp_valid_o` exactly 2 cycles later with res 12, id 0, addr 3, wb 1.
- Back-to-back: r1 issues ADD i+1 for i=0..7 every cycle with `rsp_ready_i`=1 -> 8 responses on consecutive cycles, in order, id 1, no stall.
- Backpressure: `rsp_ready_i`=0, both requesters valid -> exactly 2 issues accepted, then ready low. Release -> responses in issue order, no loss or duplication.
- Contention, RR defined: both valid for 4 issues -> grant order 0,1,0,1. Undefined -> 0,0,0,0 while r0 stays valid.
- SUB overflow passthrough: r0 SUB 0-1 -> res 0xFFFFFFFF, `rsp_overflow_o` equal to the ALU's carry for that op.
- Reset with FIFO full and one in flight -> next cycle `rsp_valid_o`=0, ready restored, the first post-reset response is id 0 (RR pointer reset).

Source files
------------

// File: rtl/jedro_1_alu_arb_if.sv
// Bundle of request, ALU-drive and response signals around jedro_1_alu_arb.
// The arbiter uses the slave modport; the requesters/ALU/consumer side uses master.
interface jedro_1_alu_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 5
);
  logic                  r0_valid_i, r0_ready_o, r0_wb_i;
  logic [OP_WIDTH-1:0]   r0_op_i;
  logic [DATA_WIDTH-1:0] r0_opa_i, r0_opb_i;
  logic [ADDR_WIDTH-1:0] r0_addr_i;

  logic                  r1_valid_i, r1_ready_o, r1_wb_i;
  logic [OP_WIDTH-1:0]   r1_op_i;
  logic [DATA_WIDTH-1:0] r1_opa_i, r1_opb_i;
  logic [ADDR_WIDTH-1:0] r1_addr_i;

  logic [OP_WIDTH-1:0]   alu_op_sel_o;
  logic [DATA_WIDTH-1:0] alu_opa_o, alu_opb_o;
  logic [ADDR_WIDTH-1:0] alu_dest_addr_o;
  logic                  alu_wb_o;

  logic [DATA_WIDTH-1:0] alu_res_i;
  logic                  alu_overflow_i;
  logic [ADDR_WIDTH-1:0] alu_dest_addr_i;
  logic                  alu_wb_i;

  logic                  rsp_valid_o, rsp_ready_i, rsp_id_o;
  logic [DATA_WIDTH-1:0] rsp_res_o;
  logic                  rsp_overflow_o;
  logic [ADDR_WIDTH-1:0] rsp_addr_o;
  logic                  rsp_wb_o;

  modport slave (
    input  r0_valid_i, r0_op_i, r0_opa_i, r0_opb_i, r0_addr_i, r0_wb_i,
    input  r1_valid_i, r1_op_i, r1_opa_i, r1_opb_i, r1_addr_i, r1_wb_i,
    output r0_ready_o, r1_ready_o,
    output alu_op_sel_o, alu_opa_o, alu_opb_o, alu_dest_addr_o, alu_wb_o,
    input  alu_res_i, alu_overflow_i, alu_dest_addr_i, alu_wb_i,
    output rsp_valid_o, rsp_id_o, rsp_res_o, rsp_overflow_o, rsp_addr_o, rsp_wb_o,
    input  rsp_ready_i
  );

  modport master (
    output r0_valid_i, r0_op_i, r0_opa_i, r0_opb_i, r0_addr_i, r0_wb_i,
    output r1_valid_i, r1_op_i, r1_opa_i, r1_opb_i, r1_addr_i, r1_wb_i,
    input  r0_ready_o, r1_ready_o,
    input  alu_op_sel_o, alu_opa_o, alu_opb_o, alu_dest_addr_o, alu_wb_o,
    output alu_res_i, alu_overflow_i, alu_dest_addr_i, alu_wb_i,
    input  rsp_valid_o, rsp_id_o, rsp_res_o, rsp_overflow_o, rsp_addr_o, rsp_wb_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/jedro_1_alu_arb.sv
// Two-requester arbiter/sequencer in front of the registered jedro_1_alu, with a 2-entry in-order response FIFO.
// Define JEDRO_1_ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module jedro_1_alu_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  jedro_1_alu_arb_if.slave    bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] res;
    logic                  ovf;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wb;
    logic                  id;
  } rsp_t;

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       can_issue;
  logic       issue;
  logic       pop;
  logic       push;
  logic [1:0] occupancy;

  logic       inflight_q, inflight_d;
  logic       inflight_id_q, inflight_id_d;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  rsp_t       mem_q [2];
  rsp_t       mem_d [2];
  rsp_t       new_entry;
  rsp_t       head;

  assign req_valid = {bus.r1_valid_i, bus.r0_valid_i};

`ifdef JEDRO_1_ALU_ARB_RR_EN
  logic last_id_q, last_id_d;

  // On contention favour whichever requester did not win the last actual issue.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_id_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_id_d = last_id_q;
    if (issue) begin
      last_id_d = grant[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_id_q <= 1'b1;
    end else begin
      last_id_q <= last_id_d;
    end
  end
`else
  always_comb begin
    grant = 2'b00;
    if (req_valid[0]) begin
      grant = 2'b01;
    end else if (req_valid[1]) begin
      grant = 2'b10;
    end
  end
`endif

  // Credit: the in-flight op plus buffered results may never exceed the FIFO depth.
  always_comb begin
    occupancy = count_q + {1'b0, inflight_q};
    pop       = (count_q != 2'd0) && bus.rsp_ready_i;
    can_issue = (occupancy < 2'd2) || ((occupancy == 2'd2) && pop);
    issue     = (grant != 2'b00) && can_issue;
    push      = inflight_q;
  end

  assign bus.r0_ready_o = grant[0] && can_issue;
  assign bus.r1_ready_o = grant[1] && can_issue;

  always_comb begin
    bus.alu_op_sel_o    = '0;
    bus.alu_opa_o       = '0;
    bus.alu_opb_o       = '0;
    bus.alu_dest_addr_o = '0;
    bus.alu_wb_o        = 1'b0;
    if (issue) begin
      if (grant[1]) begin
        bus.alu_op_sel_o    = bus.r1_op_i;
        bus.alu_opa_o       = bus.r1_opa_i;
        bus.alu_opb_o       = bus.r1_opb_i;
        bus.alu_dest_addr_o = bus.r1_addr_i;
        bus.alu_wb_o        = bus.r1_wb_i;
      end else begin
        bus.alu_op_sel_o    = bus.r0_op_i;
        bus.alu_opa_o       = bus.r0_opa_i;
        bus.alu_opb_o       = bus.r0_opb_i;
        bus.alu_dest_addr_o = bus.r0_addr_i;
        bus.alu_wb_o        = bus.r0_wb_i;
      end
    end
  end

  always_comb begin
    inflight_d    = issue;
    inflight_id_d = grant[1];
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d      = wr_ptr_q ^ push;
    rd_ptr_d      = rd_ptr_q ^ pop;
    new_entry     = '{res:  bus.alu_res_i,
                      ovf:  bus.alu_overflow_i,
                      addr: bus.alu_dest_addr_i,
                      wb:   bus.alu_wb_i,
                      id:   inflight_id_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      always_comb begin
        mem_d[gi] = mem_q[gi];
        if (push && (wr_ptr_q == 1'(gi))) begin
          mem_d[gi] = new_entry;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          mem_q[gi] <= '0;
        end else begin
          mem_q[gi] <= mem_d[gi];
        end
      end
    end
  endgenerate

  // Payload is forced to zero while empty so stale entries never leak out.
  always_comb begin
    head               = mem_q[rd_ptr_q];
    bus.rsp_valid_o    = (count_q != 2'd0);
    bus.rsp_id_o       = 1'b0;
    bus.rsp_res_o      = '0;
    bus.rsp_overflow_o = 1'b0;
    bus.rsp_addr_o     = '0;
    bus.rsp_wb_o       = 1'b0;
    if (count_q != 2'd0) begin
      bus.rsp_id_o       = head.id;
      bus.rsp_res_o      = head.res;
      bus.rsp_overflow_o = head.ovf;
      bus.rsp_addr_o     = head.addr;
      bus.rsp_wb_o       = head.wb;
    end
  end

endmodule

// File: tb/tb_jedro_1_alu_arb.sv
// Directed bench for jedro_1_alu_arb with a behavioural registered ALU stub (ADD/SUB, carry/borrow as overflow).
module tb_jedro_1_alu_arb;
  localparam int DW = 32;
  localparam int OW = 4;
  localparam int AW = 5;
  localparam logic [OW-1:0] OP_ADD = 4'h0;
  localparam logic [OW-1:0] OP_SUB = 4'h8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jedro_1_alu_arb_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

  jedro_1_alu_arb #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ALU stub, reset together with the arbiter.
  logic [DW:0] alu_full;
  always_comb begin
    if (bus.alu_op_sel_o == OP_SUB) alu_full = {1'b0, bus.alu_opa_o} - {1'b0, bus.alu_opb_o};
    else                            alu_full = {1'b0, bus.alu_opa_o} + {1'b0, bus.alu_opb_o};
  end

  always @(posedge clk) begin
    if (rst) begin
      bus.alu_res_i       <= '0;
      bus.alu_overflow_i  <= 1'b0;
      bus.alu_dest_addr_i <= '0;
      bus.alu_wb_i        <= 1'b0;
    end else begin
      bus.alu_res_i       <= alu_full[DW-1:0];
      bus.alu_overflow_i  <= alu_full[DW];
      bus.alu_dest_addr_i <= bus.alu_dest_addr_o;
      bus.alu_wb_i        <= bus.alu_wb_o;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_r0(input logic v, input logic [OW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] ad, input logic wb);
    bus.r0_valid_i = v; bus.r0_op_i = op; bus.r0_opa_i = a;
    bus.r0_opb_i = b; bus.r0_addr_i = ad; bus.r0_wb_i = wb;
  endtask

  task automatic drive_r1(input logic v, input logic [OW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] ad, input logic wb);
    bus.r1_valid_i = v; bus.r1_op_i = op; bus.r1_opa_i = a;
    bus.r1_opb_i = b; bus.r1_addr_i = ad; bus.r1_wb_i = wb;
  endtask

  logic       bp_id1;
  logic [3:0] gnt_exp;

  initial begin
`ifdef JEDRO_1_ALU_ARB_RR_EN
    bp_id1  = 1'b1;
    gnt_exp = 4'b1010;
`else
    bp_id1  = 1'b0;
    gnt_exp = 4'b0000;
`endif
    drive_r0(0, OP_ADD, 0, 0, 0, 0);
    drive_r1(0, OP_ADD, 0, 0, 0, 0);
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk); rst = 1'b0; bus.rsp_ready_i = 1'b1;
    #1;
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_res", bus.rsp_res_o, 0);
    check("rst_alu_wb", bus.alu_wb_o, 0);
    check("rst_alu_opa", bus.alu_opa_o, 0);
    check("rst_r0_ready", bus.r0_ready_o, 0);

    // Single request: ADD 5+7 -> 12, two cycles later
    @(negedge clk); drive_r0(1, OP_ADD, 5, 7, 3, 1);
    #1;
    check("t1_r0_ready", bus.r0_ready_o, 1);
    check("t1_r1_ready", bus.r1_ready_o, 0);
    check("t1_alu_opa", bus.alu_opa_o, 5);
    check("t1_alu_wb", bus.alu_wb_o, 1);
    @(negedge clk); drive_r0(0, OP_ADD, 0, 0, 0, 0);
    #1;
    check("t1_valid_early", bus.rsp_valid_o, 0);
    check("t1_alu_idle", bus.alu_wb_o, 0);
    @(negedge clk); #1;
    check("t1_valid", bus.rsp_valid_o, 1);
    check("t1_res", bus.rsp_res_o, 12);
    check("t1_id", bus.rsp_id_o, 0);
    check("t1_addr", bus.rsp_addr_o, 3);
    check("t1_wb", bus.rsp_wb_o, 1);
    check("t1_ovf", bus.rsp_overflow_o, 0);
    @(negedge clk); #1;
    check("t1_valid_after_pop", bus.rsp_valid_o, 0);

    // Back-to-back from r1: ADD k+1, k=0..7
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 8) drive_r1(1, OP_ADD, 32'(k), 1, 5'(k), 1);
      else       drive_r1(0, OP_ADD, 0, 0, 0, 0);
      #1;
      if (k < 8) check("t2_r1_ready", bus.r1_ready_o, 1);
      if (k >= 2) begin
        check("t2_valid", bus.rsp_valid_o, 1);
        check("t2_res", bus.rsp_res_o, 32'(k - 1));
        check("t2_addr", bus.rsp_addr_o, 32'(k - 2));
        check("t2_id", bus.rsp_id_o, 1);
      end
    end
    @(negedge clk); #1;
    check("t2_drained", bus.rsp_valid_o, 0);

    // Backpressure: both valid, consumer stalled
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    drive_r0(1, OP_ADD, 10, 1, 1, 1);
    drive_r1(1, OP_ADD, 20, 2, 2, 1);
    #1;
    check("t3_c0_r0_ready", bus.r0_ready_o, 1);
    check("t3_c0_r1_ready", bus.r1_ready_o, 0);
    @(negedge clk); #1;
    check("t3_c1_r0_ready", bus.r0_ready_o, !bp_id1);
    check("t3_c1_r1_ready", bus.r1_ready_o, bp_id1);
    @(negedge clk); #1;
    check("t3_c2_r0_ready", bus.r0_ready_o, 0);
    check("t3_c2_r1_ready", bus.r1_ready_o, 0);
    @(negedge clk); #1;
    check("t3_c3_r0_ready", bus.r0_ready_o, 0);
    check("t3_c3_r1_ready", bus.r1_ready_o, 0);
    check("t3_c3_valid", bus.rsp_valid_o, 1);
    @(negedge clk);
    drive_r0(0, OP_ADD, 0, 0, 0, 0);
    drive_r1(0, OP_ADD, 0, 0, 0, 0);
    bus.rsp_ready_i = 1'b1;
    #1;
    check("t3_rsp0_valid", bus.rsp_valid_o, 1);
    check("t3_rsp0_id", bus.rsp_id_o, 0);
    check("t3_rsp0_res", bus.rsp_res_o, 11);
    @(negedge clk); #1;
    check("t3_rsp1_valid", bus.rsp_valid_o, 1);
    check("t3_rsp1_id", bus.rsp_id_o, bp_id1);
    check("t3_rsp1_res", bus.rsp_res_o, bp_id1 ? 32'd22 : 32'd11);
    @(negedge clk); #1;
    check("t3_no_dup", bus.rsp_valid_o, 0);

    // Contention: four issues with both valid
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k < 4) begin
        drive_r0(1, OP_ADD, 1, 1, 4, 1);
        drive_r1(1, OP_ADD, 2, 2, 5, 1);
      end else begin
        drive_r0(0, OP_ADD, 0, 0, 0, 0);
        drive_r1(0, OP_ADD, 0, 0, 0, 0);
      end
      #1;
      if (k < 4) begin
        check("t4_r0_ready", bus.r0_ready_o, !gnt_exp[k]);
        check("t4_r1_ready", bus.r1_ready_o, gnt_exp[k]);
      end
      if (k >= 2) begin
        check("t4_id", bus.rsp_id_o, gnt_exp[k-2]);
        check("t4_res", bus.rsp_res_o, gnt_exp[k-2] ? 32'd4 : 32'd2);
      end
    end
    @(negedge clk); #1;
    check("t4_drained", bus.rsp_valid_o, 0);

    // SUB 0-1: all ones with borrow reported as overflow
    @(negedge clk); drive_r0(1, OP_SUB, 0, 1, 7, 1);
    #1;
    check("t5_r0_ready", bus.r0_ready_o, 1);
    @(negedge clk); drive_r0(0, OP_ADD, 0, 0, 0, 0);
    @(negedge clk); #1;
    check("t5_valid", bus.rsp_valid_o, 1);
    check("t5_res", bus.rsp_res_o, 32'hFFFF_FFFF);
    check("t5_ovf", bus.rsp_overflow_o, 1);
    check("t5_addr", bus.rsp_addr_o, 7);
    @(negedge clk);

    // Reset while at full occupancy
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    drive_r0(1, OP_ADD, 3, 3, 9, 1);
    #1;
    check("t6_c0_r0_ready", bus.r0_ready_o, 1);
    @(negedge clk); #1;
    check("t6_c1_r0_ready", bus.r0_ready_o, 1);
    @(negedge clk); #1;
    check("t6_c2_r0_ready", bus.r0_ready_o, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    drive_r1(1, OP_ADD, 2, 2, 5, 1);
    #1;
    check("t6_post_valid", bus.rsp_valid_o, 0);
    check("t6_post_r0_ready", bus.r0_ready_o, 1);
    check("t6_post_r1_ready", bus.r1_ready_o, 0);
    @(negedge clk);
    drive_r0(0, OP_ADD, 0, 0, 0, 0);
    drive_r1(0, OP_ADD, 0, 0, 0, 0);
    #1;
    check("t6_early_valid", bus.rsp_valid_o, 0);
    @(negedge clk); #1;
    check("t6_valid", bus.rsp_valid_o, 1);
    check("t6_id", bus.rsp_id_o, 0);
    check("t6_res", bus.rsp_res_o, 6);
    @(negedge clk); #1;
    check("t6_no_residue", bus.rsp_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
